// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, PC step and reset defaults for the fetch stage
package fetch_unit_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int PC_INCR = 4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = '0;
  localparam int FIFO_DEPTH_DEFAULT = 3;
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem address/data, execute redirect and decode valid/ready bus
interface fetch_unit_if import fetch_unit_pkg::*; ;
  logic [ADDR_W-1:0] instructionAddress;
  logic [INSTR_W-1:0] instruction;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic out_valid;
  logic out_ready;
  logic [INSTR_W-1:0] out_instruction;
  logic [ADDR_W-1:0] out_pc;
  modport master(
    output instructionAddress, out_valid, out_instruction, out_pc,
    input instruction, redirect_valid, redirect_target, out_ready
  );
  modport slave(
    input instructionAddress, out_valid, out_instruction, out_pc,
    output instruction, redirect_valid, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with flush holding {pc, instruction} pairs
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (push) mem[wr] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= nxt(wr);
      if (pop) rd <= nxt(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rd];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one imem read per cycle and buffers returns for decode
module fetch_unit import fetch_unit_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [ADDR_W-1:0] pc, inflight_pc;
  logic inflight, issue, push, pop, full, empty;
  logic [CW-1:0] count;
  logic [ADDR_W+INSTR_W-1:0] head;
  // occupancy uses the pre-pop count so out_ready never reaches instructionAddress
  assign issue = !bus.redirect_valid && ({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);
  assign pop = !empty && bus.out_ready && !bus.redirect_valid;
  assign push = inflight && !bus.redirect_valid && (!full || pop);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      pc <= align_pc(bus.redirect_target);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc <= pc + ADDR_W'(PC_INCR);
      end
    end
  fetch_fifo #(.W(ADDR_W + INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(bus.redirect_valid),
    .push(push),
    .pop(pop),
    .push_data({inflight_pc, bus.instruction}),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  assign bus.instructionAddress = pc;
  assign bus.out_valid = !empty;
  assign bus.out_instruction = empty ? '0 : head[INSTR_W-1:0];
  assign bus.out_pc = empty ? '0 : head[ADDR_W+INSTR_W-1:INSTR_W];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch streams checked against a sequential-PC scoreboard
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] head_pc;
  logic [31:0] wrap_seq [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  fetch_unit_if b0();
  fetch_unit_if b1();
  fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a >> 2) ^ 32'hC0DE_0000;
  endfunction
  always @(posedge clk) begin
    b0.instruction <= word(b0.instructionAddress);
    b1.instruction <= word(b1.instructionAddress);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Sample the state left by the last edge, then drive inputs for the next edge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
    @(negedge clk);
    b0.out_ready = rdy;
    b0.redirect_valid = rv;
    b0.redirect_target = tgt;
    if (rv) exp_pc = tgt & ~32'h3;
    else if (b0.out_valid && rdy) begin
      chk("stream_pc", b0.out_pc, exp_pc);
      chk("stream_instr", b0.out_instruction, word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
  endtask
  initial begin
    b0.out_ready = 1'b1;
    b0.redirect_valid = 1'b0;
    b0.redirect_target = '0;
    b1.out_ready = 1'b1;
    b1.redirect_valid = 1'b0;
    b1.redirect_target = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(b0.out_valid), 32'd0);
    chk("rst_instr", b0.out_instruction, 32'd0);
    chk("rst_pc", b0.out_pc, 32'd0);
    chk("rst_addr0", b0.instructionAddress, 32'd0);
    chk("rst_addr1", b1.instructionAddress, 32'hFFFF_FFF8);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
    step(1'b1, 1'b0, '0);
    chk("first_latency_valid0", 32'(b0.out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, '0);
      chk("throughput_valid", 32'(b0.out_valid), 32'd1);
      if (i < 3) chk("wrap_pc", b1.out_pc, wrap_seq[i]);
    end
    step(1'b0, 1'b0, '0);
    head_pc = b0.out_pc;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      chk("stall_valid", 32'(b0.out_valid), 32'd1);
      chk("stall_head", b0.out_pc, head_pc);
    end
    chk("stall_addr", b0.instructionAddress, head_pc + 32'd12);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h100);
    step(1'b1, 1'b0, '0);
    chk("redir_valid0", 32'(b0.out_valid), 32'd0);
    chk("redir_addr", b0.instructionAddress, 32'h100);
    step(1'b1, 1'b0, '0);
    chk("redir_valid1", 32'(b0.out_valid), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("redir_valid2", 32'(b0.out_valid), 32'd1);
    chk("redir_pc", b0.out_pc, 32'h100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    chk("pop_redir_pre_valid", 32'(b0.out_valid), 32'd1);
    step(1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b0, '0);
    chk("pop_redir_valid0", 32'(b0.out_valid), 32'd0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("pop_redir_pc", b0.out_pc, 32'h200);
    chk("pop_redir_instr", b0.out_instruction, word(32'h200));
    step(1'b1, 1'b1, 32'h103);
    step(1'b1, 1'b0, '0);
    chk("align_addr", b0.instructionAddress, 32'h100);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("align_pc", b0.out_pc, 32'h100);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(b0.out_valid), 32'd0);
    chk("async_rst_pc", b0.out_pc, 32'd0);
    chk("async_rst_instr", b0.out_instruction, 32'd0);
    chk("async_rst_addr0", b0.instructionAddress, 32'd0);
    chk("async_rst_addr1", b1.instructionAddress, 32'hFFFF_FFF8);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
    step(1'b1, 1'b0, '0);
    chk("refetch_valid0", 32'(b0.out_valid), 32'd0);
    step(1'b1, 1'b0, '0);
    chk("refetch_pc", b0.out_pc, 32'd0);
    chk("refetch_valid1", 32'(b0.out_valid), 32'd1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
